// File: rtl/hs_arb_pkg.sv
// Shared types and helpers for the clocked four-phase arbitrated call element.
package hs_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALL = 2'd1,
        HOLD = 2'd2,
        RTZ  = 2'd3
    } arb_state_e;

    localparam int SYNC_DEPTH = 2;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hs_arbiter_call_if.sv
// Requester/resource handshake bundle; slave is the arbiter side.
interface hs_arbiter_call_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] ack_o;
    logic [N_REQ-1:0] grant_o;
    logic             res_req_o;
    logic             res_ack_i;

    modport master (
        output req_i, res_ack_i,
        input  ack_o, grant_o, res_req_o
    );

    modport slave (
        input  req_i, res_ack_i,
        output ack_o, grant_o, res_req_o
    );
endinterface

// File: rtl/hs_rr_pick.sv
// Combinational picker: first set request at or after ptr (rotating) or lowest index (fixed).
module hs_rr_pick
    import hs_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int PW          = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [PW-1:0]    win_idx,
    output logic             win_vld
);

    always_comb begin : pick
        int          idx;
        logic [PW-1:0] idx_p;
        idx     = 0;
        idx_p   = '0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (ROUND_ROBIN ? int'(ptr) : 0) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_p = PW'(idx);
            if (!win_vld && req[idx_p]) begin
                win_vld        = 1'b1;
                win_oh[idx_p]  = 1'b1;
                win_idx        = idx_p;
            end
        end
    end

endmodule

// File: rtl/hs_arbiter_call.sv
// N-way clocked arbitrated call for four-phase req/ack channels.
// Define HS_ARB_SYNC_EN to put 2-flop synchronizers on req_i and res_ack_i.
module hs_arbiter_call
    import hs_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    hs_arbiter_call_if.slave   bus
);

    localparam int PW = ptr_w(N_REQ);

    logic [N_REQ-1:0] req_s;
    logic             res_ack_s;

`ifdef HS_ARB_SYNC_EN
    logic [SYNC_DEPTH-1:0][N_REQ-1:0] req_pipe;
    logic [SYNC_DEPTH-1:0]            ack_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pipe <= '0;
            ack_pipe <= '0;
        end else begin
            req_pipe <= {req_pipe[SYNC_DEPTH-2:0], bus.req_i};
            ack_pipe <= {ack_pipe[SYNC_DEPTH-2:0], bus.res_ack_i};
        end
    end

    assign req_s     = req_pipe[SYNC_DEPTH-1];
    assign res_ack_s = ack_pipe[SYNC_DEPTH-1];
`else
    assign req_s     = bus.req_i;
    assign res_ack_s = bus.res_ack_i;
`endif

    arb_state_e       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ack;
    logic             res_req;

    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_vld;

    hs_rr_pick #(
        .N_REQ       (N_REQ),
        .ROUND_ROBIN (ROUND_ROBIN),
        .PW          (PW)
    ) u_pick (
        .req     (req_s),
        .ptr     (ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // Only the winner's req is looked at once busy; other requesters wait for IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            grant   <= '0;
            ack     <= '0;
            res_req <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    grant   <= pick_oh;
                    win     <= pick_idx;
                    res_req <= 1'b1;
                    state   <= CALL;
                end
                CALL: if (res_ack_s) begin
                    ack   <= grant;
                    state <= HOLD;
                end
                HOLD: if (!req_s[win]) begin
                    res_req <= 1'b0;
                    state   <= RTZ;
                end
                RTZ: if (!res_ack_s) begin
                    ack   <= '0;
                    grant <= '0;
                    state <= IDLE;
                    if (ROUND_ROBIN)
                        ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack_o     = ack;
    assign bus.grant_o   = grant;
    assign bus.res_req_o = res_req;

endmodule

// File: tb/tb_hs_arbiter_call.sv
// Bench: directed scenarios plus randomized traffic on a round-robin and a fixed-priority instance,
// each checked every cycle against a transaction-level model.
module tb_hs_arbiter_call;

    localparam int N = 4;
`ifdef HS_ARB_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hs_arbiter_call_if #(.N_REQ(N)) if0 ();
    hs_arbiter_call_if #(.N_REQ(N)) if1 ();

    logic [N-1:0] req_drv  [2];
    logic         rack_drv [2];
    logic [N-1:0] grant_w  [2];
    logic [N-1:0] ack_w    [2];
    logic         rreq_w   [2];

    assign if0.req_i     = req_drv[0];
    assign if0.res_ack_i = rack_drv[0];
    assign if1.req_i     = req_drv[1];
    assign if1.res_ack_i = rack_drv[1];
    assign grant_w[0] = if0.grant_o;
    assign ack_w[0]   = if0.ack_o;
    assign rreq_w[0]  = if0.res_req_o;
    assign grant_w[1] = if1.grant_o;
    assign ack_w[1]   = if1.ack_o;
    assign rreq_w[1]  = if1.res_req_o;

    hs_arbiter_call #(.N_REQ(N), .ROUND_ROBIN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    hs_arbiter_call #(.N_REQ(N), .ROUND_ROBIN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        check(nm, {{(N-1){1'b0}}, act}, {{(N-1){1'b0}}, exp});
    endtask

    // Transaction-level model: a grant is a transaction with three milestones
    // (resource acked, requester released, resource returned to zero).
    bit  m_busy [2];
    bit  m_acked[2];
    bit  m_rel  [2];
    int  m_own  [2];
    int  m_ptr  [2];
    logic [N-1:0] h_req[2][3];
    logic         h_ack[2][3];

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++)
            if (r[(start + i) % N]) return (start + i) % N;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] r, eg, ea;
        logic         a;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 0; m_acked[k] = 0; m_rel[k] = 0; m_own[k] = 0; m_ptr[k] = 0;
                for (int d = 0; d < 3; d++) begin h_req[k][d] = '0; h_ack[k][d] = 1'b0; end
            end else begin
                for (int d = 2; d > 0; d--) begin
                    h_req[k][d] = h_req[k][d-1];
                    h_ack[k][d] = h_ack[k][d-1];
                end
                h_req[k][0] = req_drv[k];
                h_ack[k][0] = rack_drv[k];
                r = h_req[k][SD];
                a = h_ack[k][SD];
                if (!m_busy[k]) begin
                    if (r != '0) begin
                        m_own[k] = pick(r, (k == 0) ? m_ptr[k] : 0);
                        m_busy[k] = 1; m_acked[k] = 0; m_rel[k] = 0;
                    end
                end else if (!m_acked[k]) begin
                    if (a) m_acked[k] = 1;
                end else if (!m_rel[k]) begin
                    if (!r[m_own[k]]) m_rel[k] = 1;
                end else if (!a) begin
                    m_busy[k] = 0;
                    if (k == 0) m_ptr[k] = (m_own[k] + 1) % N;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            eg = '0;
            if (m_busy[k]) eg[m_own[k]] = 1'b1;
            ea = m_acked[k] ? eg : '0;
            check($sformatf("model dut%0d grant", k), grant_w[k], eg);
            check($sformatf("model dut%0d ack", k), ack_w[k], ea);
            chk1($sformatf("model dut%0d res_req", k), rreq_w[k], m_busy[k] && !m_rel[k]);
            chk1($sformatf("inv dut%0d onehot", k), $countones(grant_w[k]) <= 1, 1'b1);
            chk1($sformatf("inv dut%0d ack_in_grant", k), (ack_w[k] & ~grant_w[k]) == '0, 1'b1);
            chk1($sformatf("inv dut%0d req_has_grant", k), !rreq_w[k] || (grant_w[k] != '0), 1'b1);
        end
    end

    task automatic do_edges(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_drv[0] = '0; req_drv[1] = '0;
        rack_drv[0] = 1'b0; rack_drv[1] = 1'b0;
        do_edges(2);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // sel: 0 grant, 1 ack, 2 res_req
    task automatic wait_sig(input int k, input int sel, input logic [N-1:0] val, input string nm);
        logic [N-1:0] cur;
        cur = '0;
        for (int t = 0; t < 60; t++) begin
            cur = (sel == 0) ? grant_w[k] : (sel == 1) ? ack_w[k] : {{(N-1){1'b0}}, rreq_w[k]};
            if (cur === val) break;
            do_edges(1);
        end
        check(nm, cur, val);
    endtask

    task automatic serve(input int k, input logic [N-1:0] exp, input bit rereq);
        wait_sig(k, 0, exp, $sformatf("dut%0d grant", k));
        rack_drv[k] = 1'b1;
        wait_sig(k, 1, exp, $sformatf("dut%0d ack rise", k));
        req_drv[k] = req_drv[k] & ~exp;
        wait_sig(k, 2, '0, $sformatf("dut%0d res_req fall", k));
        rack_drv[k] = 1'b0;
        wait_sig(k, 1, '0, $sformatf("dut%0d ack fall", k));
        if (rereq) req_drv[k] = req_drv[k] | exp;
    endtask

    task automatic rand_step();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!req_drv[k][j] && !ack_w[k][j]) begin
                    if ($urandom_range(3) == 0) req_drv[k][j] = 1'b1;
                end else if (req_drv[k][j] && ack_w[k][j]) begin
                    if ($urandom_range(1) == 0) req_drv[k][j] = 1'b0;
                end else if (req_drv[k][j]) begin
                    if (grant_w[k][j] ? ($urandom_range(15) == 0) : ($urandom_range(31) == 0))
                        req_drv[k][j] = 1'b0;
                end
            end
            if (rreq_w[k] && !rack_drv[k]) begin
                if ($urandom_range(1) == 0) rack_drv[k] = 1'b1;
            end else if (!rreq_w[k] && rack_drv[k]) begin
                if ($urandom_range(1) == 0) rack_drv[k] = 1'b0;
            end else if (!rreq_w[k] && grant_w[k] == '0 && $urandom_range(31) == 0) begin
                rack_drv[k] = 1'b1;
            end
        end
    endtask

    logic [N-1:0] fp_exp [3];

    initial begin
        req_drv[0] = '0; req_drv[1] = '0;
        rack_drv[0] = 1'b0; rack_drv[1] = 1'b0;
        fp_exp[0] = 4'b0001;
        fp_exp[1] = (SD == 0) ? 4'b0001 : 4'b0010;
        fp_exp[2] = 4'b0001;

        do_edges(2);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset dut%0d grant", k), grant_w[k], '0);
            check($sformatf("reset dut%0d ack", k), ack_w[k], '0);
            chk1($sformatf("reset dut%0d res_req", k), rreq_w[k], 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;

        // single requester
        req_drv[0] = 4'b0001;
        do_edges(1 + SD);
        chk1("single res_req rise", rreq_w[0], 1'b1);
        check("single grant", grant_w[0], 4'b0001);
        check("single ack before res_ack", ack_w[0], 4'b0000);
        rack_drv[0] = 1'b1;
        do_edges(1 + SD);
        check("single ack rise", ack_w[0], 4'b0001);
        req_drv[0] = 4'b0000;
        do_edges(1 + SD);
        chk1("single res_req fall", rreq_w[0], 1'b0);
        check("single ack held", ack_w[0], 4'b0001);
        rack_drv[0] = 1'b0;
        do_edges(1 + SD);
        check("single ack fall", ack_w[0], 4'b0000);
        check("single grant end", grant_w[0], 4'b0000);

        // contention, rotating then fixed priority
        do_reset();
        req_drv[0] = 4'b1111;
        serve(0, 4'b0001, 1'b1);
        serve(0, 4'b0010, 1'b1);
        serve(0, 4'b0100, 1'b1);
        serve(0, 4'b1000, 1'b1);
        serve(0, 4'b0001, 1'b1);
        do_reset();
        req_drv[1] = 4'b1111;
        for (int i = 0; i < 3; i++) serve(1, fp_exp[i], 1'b1);

        // late arrival while busy
        do_reset();
        req_drv[0] = 4'b0100;
        do_edges(1 + SD);
        check("late grant", grant_w[0], 4'b0100);
        rack_drv[0] = 1'b1;
        do_edges(1 + SD);
        check("late ack", ack_w[0], 4'b0100);
        req_drv[0] = 4'b0110;
        do_edges(2);
        check("late grant held", grant_w[0], 4'b0100);
        check("late ack held", ack_w[0], 4'b0100);
        req_drv[0] = 4'b0010;
        do_edges(1 + SD);
        chk1("late res_req fall", rreq_w[0], 1'b0);
        check("late grant in rtz", grant_w[0], 4'b0100);
        rack_drv[0] = 1'b0;
        do_edges(1 + SD);
        check("late idle grant", grant_w[0], 4'b0000);
        check("late idle ack", ack_w[0], 4'b0000);
        do_edges(1);
        check("late next grant", grant_w[0], 4'b0010);
        serve(0, 4'b0010, 1'b0);

        // reset in the middle of a handshake
        do_reset();
        req_drv[0] = 4'b0100;
        wait_sig(0, 0, 4'b0100, "rst grant");
        rack_drv[0] = 1'b1;
        wait_sig(0, 1, 4'b0100, "rst ack");
        req_drv[0] = 4'b0000;
        wait_sig(0, 2, '0, "rst res_req low");
        #2;
        reset = 1'b1;
        #1;
        check("async rst ack", ack_w[0], '0);
        check("async rst grant", grant_w[0], '0);
        chk1("async rst res_req", rreq_w[0], 1'b0);
        rack_drv[0] = 1'b0;
        req_drv[0] = 4'b0001;
        do_edges(2);
        @(negedge clk);
        reset = 1'b0;
        do_edges(1 + SD);
        check("post rst grant", grant_w[0], 4'b0001);
        serve(0, 4'b0001, 1'b0);

        // requester drops before its ack
        req_drv[0] = 4'b0100;
        wait_sig(0, 0, 4'b0100, "viol grant");
        req_drv[0] = 4'b0000;
        rack_drv[0] = 1'b1;
        wait_sig(0, 1, 4'b0100, "viol ack pulse");
        wait_sig(0, 2, '0, "viol res_req fall");
        rack_drv[0] = 1'b0;
        wait_sig(0, 1, '0, "viol ack fall");
        check("viol grant idle", grant_w[0], '0);

        repeat (3000) begin
            @(negedge clk);
            rand_step();
        end

        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (grant_w[0] == '0 && grant_w[1] == '0 && !rack_drv[0] && !rack_drv[1]) break;
            req_drv[0] = '0; req_drv[1] = '0;
            rack_drv[0] = rreq_w[0];
            rack_drv[1] = rreq_w[1];
        end
        do_edges(1);
        check("drain dut0 grant", grant_w[0], '0);
        check("drain dut1 grant", grant_w[1], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
